muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative M-extension execute unit for the 5-stage RV32IM pipeline. Sits in the execute stage beside the ALU.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with a shift-add multiplier and a restoring divider, both radix-2.
- Drives `busy` to the hazard logic, which stalls F/D/E while it is high. Presents `result` with a one-cycle `done` pulse so the instruction can advance to memory.

Parameters:
- XLEN, 32, operand/result width; also the iteration count.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_e  in  1  M-extension instruction present in execute (held high by the pipeline while stalled).
- funct3_e  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a_e  in  XLEN  rs1 value after forwarding.
- op_b_e  in  XLEN  rs2 value after forwarding.
- flush_e  in  1  abort the current operation (branch/flush of execute).
- busy  out  1  stall request to the hazard logic.
- done  out  1  result valid this cycle.
- result  out  XLEN  operation result.

Behaviour:
- Reset (async): state=IDLE, counter=0, all accumulators 0, result=0, done=0, busy=0.
- States:
  - IDLE: on start_e && !flush_e, latch funct3_e, operands and sign flags, then go to PREP.
  - PREP: take operand magnitudes according to the op's signedness (MULHSU: only op_a signed; *U ops: none). Special cases go directly to FIN:
    - Divisor 0: quotient=all ones, remainder=dividend.
    - Signed overflow (DIV/REM with -2^(XLEN-1) / -1): quotient=-2^(XLEN-1), remainder=0.
    - Otherwise go to CALC with counter=0.
  - CALC: one iteration per cycle; go to FIN after counter reaches XLEN-1 (XLEN iterations).
    - Multiply: 2*XLEN-bit accumulator, add multiplicand if multiplier LSB=1, then shift.
    - Divide: restoring; shift remainder:dividend left by 1, subtract divisor, keep if non-negative, and set the quotient bit.
  - FIN: apply sign correction, register `result`, done=1, busy=0. Go to IDLE on the next edge unconditionally; start_e is ignored in FIN.
- Sign correction:
  - Product: negated in full 2*XLEN bits if sign_a^sign_b (signed ops only).
  - Quotient: negated if signs differ.
  - Remainder: takes the sign of the dividend.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits; all arithmetic is modulo 2^XLEN.
- busy = (IDLE && start_e && !flush_e) || PREP || CALC. This is combinational so the stall applies in the issue cycle.
- Latency, with the issue cycle as cycle 0:
  - Normal: PREP cycle 1, CALC cycles 2..XLEN+1, FIN cycle XLEN+2 (34 for XLEN=32).
  - Special case: FIN at cycle 2.
- `result` holds the last completed value outside FIN. `done` is high only in FIN.
- flush_e has priority in every state: next state IDLE, no done, busy=0 combinationally in that cycle. An operation aborted in CALC leaves `result` unchanged.
- Reset mid-operation: immediate return to reset values; no done.
- Back-to-back: a new start_e in the cycle after FIN (state IDLE) is accepted normally.

Decomposition:
- Shared header muldiv_defs.vh:
  - funct3 constants (F3_MUL..F3_REMU).
  - State encoding (IDLE/PREP/CALC/FIN, 2 bits).
  - XLEN default.
- One sub-module, muldiv_sign_fix: combinational conditional two's-complement negate, parameterised width. Used for the operand magnitude in PREP and the result correction in FIN.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3), start at cycle 0: busy high cycles 0–33; done at cycle 34 with result=0xFFFFFFEB.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2. All complete at cycle 34.
- DIVU 5/0 → 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM same operands → 0. Each: done at cycle 2, busy high only cycles 0–1.
- DIV issued, flush_e pulsed at cycle 10 → busy=0 at cycle 10, state IDLE at cycle 11, no done, result unchanged. Separately, rst asserted mid-CALC → all outputs 0 immediately.
- Back-to-back MUL 3×4 then MUL 5×6 (start_e held through FIN, new operands at cycle 35): first done at cycle 34 with 12; second accepted at cycle 35, done at cycle 69 with 30.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared types, opcodes and signedness helpers for the M-extension unit
package muldiv_unit_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIN  = 2'd3
    } state_t;

    // MUL only needs the low half, which is sign-agnostic; treating it as signed is harmless.
    function automatic logic op_signed_a(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - execute-stage handshake between the pipeline and the mul/div unit
interface muldiv_unit_if
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            start_e;
    logic [2:0]      funct3_e;
    logic [XLEN-1:0] op_a_e;
    logic [XLEN-1:0] op_b_e;
    logic            flush_e;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start_e, funct3_e, op_a_e, op_b_e, flush_e,
        input  busy, done, result
    );

    modport slave (
        input  start_e, funct3_e, op_a_e, op_b_e, flush_e,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit_sign_fix.sv
// rtl/muldiv_unit_sign_fix.sv - conditional two's-complement negate
module muldiv_unit_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] fixed
);
    assign fixed = negate ? (~value + W'(1)) : value;
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 shift-add multiplier and restoring divider for RV32M
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave io
);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        f3;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic [XLEN-1:0]   mag_b;
    logic              neg_res;
    logic              neg_rem;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    logic [XLEN-1:0]   mag_a_w;
    logic [XLEN-1:0]   mag_b_w;
    logic              is_div;
    logic              prep_special;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;

    logic [XLEN-1:0]   nxt_hi;
    logic [XLEN-1:0]   nxt_lo;
    logic              nxt_neg_res;
    logic              nxt_neg_rem;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fin_value;

    muldiv_unit_sign_fix #(.W(XLEN)) u_fix_a (
        .value(a_q), .negate(sign_a), .fixed(mag_a_w)
    );

    muldiv_unit_sign_fix #(.W(XLEN)) u_fix_b (
        .value(b_q), .negate(sign_b), .fixed(mag_b_w)
    );

    assign is_div       = f3[2];
    assign prep_special = is_div && ((b_q == '0) ||
                          (((f3 == F3_DIV) || (f3 == F3_REM)) && (a_q == MIN_NEG) && (b_q == '1)));

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_trial = div_shift - {1'b0, mag_b};

    // Next accumulator contents, so the corrected result can be registered on the edge into FIN.
    always_comb begin
        nxt_hi      = acc_hi;
        nxt_lo      = acc_lo;
        nxt_neg_res = neg_res;
        nxt_neg_rem = neg_rem;
        unique case (state)
            PREP: begin
                if (is_div && (b_q == '0)) begin
                    nxt_hi      = a_q;
                    nxt_lo      = '1;
                    nxt_neg_res = 1'b0;
                    nxt_neg_rem = 1'b0;
                end else if (prep_special) begin
                    nxt_hi      = '0;
                    nxt_lo      = MIN_NEG;
                    nxt_neg_res = 1'b0;
                    nxt_neg_rem = 1'b0;
                end else begin
                    nxt_hi      = '0;
                    nxt_lo      = mag_a_w;
                    nxt_neg_res = sign_a ^ sign_b;
                    nxt_neg_rem = sign_a;
                end
            end
            CALC: begin
                if (is_div) begin
                    if (!div_trial[XLEN]) begin
                        nxt_hi = div_trial[XLEN-1:0];
                        nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
                    end else begin
                        nxt_hi = div_shift[XLEN-1:0];
                        nxt_lo = {acc_lo[XLEN-2:0], 1'b0};
                    end
                end else begin
                    {nxt_hi, nxt_lo} = {mul_sum, acc_lo[XLEN-1:1]};
                end
            end
            default: ;
        endcase
    end

    muldiv_unit_sign_fix #(.W(2*XLEN)) u_fix_prod (
        .value({nxt_hi, nxt_lo}), .negate(nxt_neg_res), .fixed(prod_fix)
    );

    muldiv_unit_sign_fix #(.W(XLEN)) u_fix_rem (
        .value(nxt_hi), .negate(nxt_neg_rem), .fixed(rem_fix)
    );

    // The low half of the negated product equals the negated quotient held in nxt_lo.
    always_comb begin
        fin_value = prod_fix[XLEN-1:0];
        unique case (f3)
            F3_MUL, F3_DIV, F3_DIVU:      fin_value = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fin_value = prod_fix[2*XLEN-1:XLEN];
            F3_REM, F3_REMU:              fin_value = rem_fix;
            default:                      fin_value = prod_fix[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            f3       <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            mag_b    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (io.flush_e) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (io.start_e) begin
                            f3     <= io.funct3_e;
                            a_q    <= io.op_a_e;
                            b_q    <= io.op_b_e;
                            sign_a <= io.op_a_e[XLEN-1] & op_signed_a(io.funct3_e);
                            sign_b <= io.op_b_e[XLEN-1] & op_signed_b(io.funct3_e);
                            state  <= PREP;
                        end
                    end
                    PREP: begin
                        acc_hi  <= nxt_hi;
                        acc_lo  <= nxt_lo;
                        mag_b   <= mag_b_w;
                        neg_res <= nxt_neg_res;
                        neg_rem <= nxt_neg_rem;
                        cnt     <= '0;
                        if (prep_special) begin
                            result_q <= fin_value;
                            done_q   <= 1'b1;
                            state    <= FIN;
                        end else begin
                            state <= CALC;
                        end
                    end
                    CALC: begin
                        acc_hi <= nxt_hi;
                        acc_lo <= nxt_lo;
                        cnt    <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(XLEN-1)) begin
                            result_q <= fin_value;
                            done_q   <= 1'b1;
                            state    <= FIN;
                        end
                    end
                    FIN: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Combinational so the hazard unit stalls in the issue cycle and releases on a flush.
    assign io.busy   = !io.flush_e &&
                       (((state == IDLE) && io.start_e) || (state == PREP) || (state == CALC));
    assign io.done   = done_q && !io.flush_e;
    assign io.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    muldiv_unit_if #(.XLEN(32)) io ();

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          d1_at, d2_at, done_seen;
    logic [31:0] d1_res, d2_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called just after a rising edge; holds start_e through FIN and drops it the cycle after.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int          done_at = -1;
        int          busy_n  = 0;
        int          done_n  = 0;
        logic [31:0] res     = '0;
        io.start_e  = 1'b1;
        io.funct3_e = f3;
        io.op_a_e   = a;
        io.op_b_e   = b;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (io.busy) busy_n++;
            if (io.done) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = cyc;
                    res     = io.result;
                end
            end
            @(posedge clk);
            #1;
            if (done_at >= 0 && cyc == done_at) io.start_e = 1'b0;
            if (done_at >= 0 && cyc == done_at + 1) break;
        end
        io.start_e = 1'b0;
        chk({tag, " result"}, res, exp_res);
        chk({tag, " done cycle"}, 32'(done_at), 32'(exp_lat));
        chk({tag, " busy cycles"}, 32'(busy_n), 32'(exp_lat));
        chk({tag, " done pulses"}, 32'(done_n), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        io.start_e  = 1'b0;
        io.funct3_e = F3_MUL;
        io.op_a_e   = '0;
        io.op_b_e   = '0;
        io.flush_e  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy",   32'(io.busy), 32'd0);
        chk("reset done",   32'(io.done), 32'd0);
        chk("reset result", io.result,    32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("MUL 7*-3",     F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("MULH min*min", F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
        run_op("MULHU max",    F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("MULHSU -1",    F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run_op("DIV -7/2",     F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
        run_op("REM -7/2",     F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
        run_op("DIVU 100/7",   F3_DIVU,   32'd100,        32'd7,         32'd14,        34);
        run_op("REMU 100/7",   F3_REMU,   32'd100,        32'd7,         32'd2,         34);

        // Flush mid-CALC: last completed result is 2 and must survive.
        done_seen   = 0;
        io.start_e  = 1'b1;
        io.funct3_e = F3_DIV;
        io.op_a_e   = 32'd100;
        io.op_b_e   = 32'd7;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == 10) begin
                io.flush_e = 1'b1;
                io.start_e = 1'b0;
            end
            if (cyc == 11) io.flush_e = 1'b0;
            @(negedge clk);
            if (io.done) done_seen++;
            if (cyc == 9)  chk("flush busy before", 32'(io.busy), 32'd1);
            if (cyc == 10) chk("flush busy at flush", 32'(io.busy), 32'd0);
            if (cyc == 11) chk("flush busy after", 32'(io.busy), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("flush no done", 32'(done_seen), 32'd0);
        chk("flush result kept", io.result, 32'd2);

        run_op("DIVU after flush", F3_DIVU, 32'd100, 32'd9, 32'd11, 34);

        // Asynchronous reset mid-CALC clears outputs without waiting for an edge.
        io.start_e  = 1'b1;
        io.funct3_e = F3_MUL;
        io.op_a_e   = 32'd3;
        io.op_b_e   = 32'd4;
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        chk("pre-reset busy", 32'(io.busy), 32'd1);
        io.start_e = 1'b0;
        rst        = 1'b1;
        #1;
        chk("midop reset busy",   32'(io.busy), 32'd0);
        chk("midop reset done",   32'(io.done), 32'd0);
        chk("midop reset result", io.result,    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_op("DIVU 5/0",    F3_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 2);
        run_op("REM 5/0",     F3_REM,  32'd5,         32'd0,         32'd5,         2);
        run_op("DIV ovf",     F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("REM ovf",     F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2);

        // Back-to-back: start_e held through FIN, new operands presented the cycle after.
        d1_at       = -1;
        d2_at       = -1;
        d1_res      = '0;
        d2_res      = '0;
        io.start_e  = 1'b1;
        io.funct3_e = F3_MUL;
        io.op_a_e   = 32'd3;
        io.op_b_e   = 32'd4;
        for (int cyc = 0; cyc < 72; cyc++) begin
            if (cyc == 35) begin
                io.op_a_e = 32'd5;
                io.op_b_e = 32'd6;
            end
            if (cyc == 70) io.start_e = 1'b0;
            @(negedge clk);
            if (cyc == 34) chk("b2b busy in FIN", 32'(io.busy), 32'd0);
            if (cyc == 35) chk("b2b busy reissue", 32'(io.busy), 32'd1);
            if (io.done) begin
                if (d1_at < 0) begin
                    d1_at  = cyc;
                    d1_res = io.result;
                end else if (d2_at < 0) begin
                    d2_at  = cyc;
                    d2_res = io.result;
                end
            end
            @(posedge clk);
            #1;
        end
        chk("b2b first cycle",  32'(d1_at), 32'd34);
        chk("b2b first result", d1_res,     32'd12);
        chk("b2b second cycle", 32'(d2_at), 32'd69);
        chk("b2b second result", d2_res,    32'd30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
